// File: rtl/data_memory_unit_pkg.sv
// ============================================================================
// data_memory_unit_pkg : default widths and FSM state encoding for the banked
// data memory.  Rev 1.0
// ============================================================================
`default_nettype none

package data_memory_unit_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_BANK_BITS  = 2;

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/data_memory_unit_array.sv
// ============================================================================
// data_memory_array : synchronous single-port RAM, registered read-before-write
// output, contents not reset.  Rev 1.0
// ============================================================================
`default_nettype none

module data_memory_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LOC_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [LOC_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << LOC_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both updates sample the pre-edge array, so a same-address read sees old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_memory_unit.sv
// ============================================================================
// data_memory_unit : banked data memory with bank/address registers, zero-fill
// sweep after reset, and a tristate read-data driver onto the shared bus. Rev 1.0
// ============================================================================
`default_nettype none

module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BANK_BITS  = DEF_BANK_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_bus,
  input  logic                  in_mbs_wr_enable,
  input  logic                  in_addr_wr_enable,
  input  logic                  in_read_enable,
  input  logic                  in_wr_enable,
  output logic [DATA_WIDTH-1:0] out_bus,
  output logic                  out_valid,
  output logic [BANK_BITS-1:0]  out_bank,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_busy
);

  localparam int LOC_WIDTH = BANK_BITS + ADDR_WIDTH;

  logic [0:0]            state_q,  state_d;
  logic [LOC_WIDTH-1:0]  sweep_q,  sweep_d;
  logic [BANK_BITS-1:0]  bank_q,   bank_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic                  valid_q,  valid_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [LOC_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SWEEP;
      sweep_q <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if (in_mbs_wr_enable) begin
          bank_d = in_bus[BANK_BITS-1:0];
        end
        if (in_addr_wr_enable) begin
          addr_d = in_bus[ADDR_WIDTH-1:0];
        end
        valid_d = in_read_enable;
      end
    endcase
  end

  // Accesses always use the pre-edge bank/address registers.
  always_comb begin
    out_busy  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = {bank_q, addr_q};
    mem_wdata = in_bus;
    case (state_q)
      ST_SWEEP: begin
        out_busy  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sweep_q;
        mem_wdata = '0;
      end
      default: begin
        mem_we = in_wr_enable;
        mem_re = in_read_enable;
      end
    endcase
  end

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOC_WIDTH  (LOC_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign out_valid = valid_q;
  assign out_bank  = bank_q;
  assign out_addr  = addr_q;
  assign out_bus   = valid_q ? mem_rdata : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
// ============================================================================
// tb_data_memory_unit : directed, table-driven bench for data_memory_unit using
// a 2-bank x 8-word configuration.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_unit;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int BB = 1;
  localparam int NLOC = 1 << (AW + BB);

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_bus;
  logic          in_mbs_wr_enable;
  logic          in_addr_wr_enable;
  logic          in_read_enable;
  logic          in_wr_enable;
  wire  [DW-1:0] out_bus;
  logic          out_valid;
  logic [BB-1:0] out_bank;
  logic [AW-1:0] out_addr;
  logic          out_busy;

  int total = 0;
  int bad   = 0;

  data_memory_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BANK_BITS  (BB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_bus            (in_bus),
    .in_mbs_wr_enable  (in_mbs_wr_enable),
    .in_addr_wr_enable (in_addr_wr_enable),
    .in_read_enable    (in_read_enable),
    .in_wr_enable      (in_wr_enable),
    .out_bus           (out_bus),
    .out_valid         (out_valid),
    .out_bank          (out_bank),
    .out_addr          (out_addr),
    .out_busy          (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          mbs;
    logic          aw;
    logic          rd;
    logic          wr;
    logic [DW-1:0] bus;
    logic          ev;
    logic [DW-1:0] eb;
    logic [BB-1:0] ebank;
    logic [AW-1:0] eaddr;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  function automatic vec_t mk(input logic mbs, input logic aw, input logic rd,
                              input logic wr, input logic [DW-1:0] bus,
                              input logic ev, input logic [DW-1:0] eb,
                              input logic [BB-1:0] ebank, input logic [AW-1:0] eaddr);
    vec_t v;
    v.mbs = mbs; v.aw = aw; v.rd = rd; v.wr = wr; v.bus = bus;
    v.ev = ev; v.eb = eb; v.ebank = ebank; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_mbs_wr_enable  = 1'b0;
    in_addr_wr_enable = 1'b0;
    in_read_enable    = 1'b0;
    in_wr_enable      = 1'b0;
    in_bus            = '0;
  endtask

  // Counts edges until busy drops; optional strobes must leave registers untouched.
  task automatic run_sweep(input bit strobes, output int cycles, output bit quiet);
    cycles = 0;
    quiet  = 1'b1;
    in_mbs_wr_enable  = strobes;
    in_addr_wr_enable = strobes;
    in_read_enable    = strobes;
    in_wr_enable      = strobes;
    in_bus            = 8'hFF;
    while (out_busy === 1'b1 && cycles < 64) begin
      tick();
      cycles++;
      if (out_bank !== '0 || out_addr !== '0 || out_valid !== 1'b0) quiet = 1'b0;
    end
    idle();
  endtask

  task automatic read_loc(input logic [BB-1:0] b, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
    in_mbs_wr_enable = 1'b1; in_bus = {{(DW-BB){1'b0}}, b};
    tick();
    idle();
    in_addr_wr_enable = 1'b1; in_bus = {{(DW-AW){1'b0}}, a};
    tick();
    idle();
    in_read_enable = 1'b1;
    tick();
    idle();
    check($sformatf("sweep_rd_b%0d_a%0d", b, a), {23'b0, out_valid, out_bus}, {23'b0, 1'b1, exp});
  endtask

  initial begin
    int  cyc;
    bit  quiet;
    logic [DW-1:0] zz;
    zz = 'z;

    vt[0]  = mk(1,0,0,0, 8'h01, 0, zz,    1, 0);
    vt[1]  = mk(0,1,0,0, 8'h05, 0, zz,    1, 5);
    vt[2]  = mk(0,0,0,1, 8'hA5, 0, zz,    1, 5);
    vt[3]  = mk(0,0,1,0, 8'h00, 1, 8'hA5, 1, 5);
    vt[4]  = mk(0,0,0,0, 8'h00, 0, zz,    1, 5);
    vt[5]  = mk(1,0,0,0, 8'h00, 0, zz,    0, 5);
    vt[6]  = mk(0,0,0,1, 8'h11, 0, zz,    0, 5);
    vt[7]  = mk(0,0,1,0, 8'h00, 1, 8'h11, 0, 5);
    vt[8]  = mk(1,0,1,0, 8'h01, 1, 8'h11, 1, 5);
    vt[9]  = mk(0,0,1,0, 8'h00, 1, 8'hA5, 1, 5);
    vt[10] = mk(0,0,0,1, 8'h22, 0, zz,    1, 5);
    vt[11] = mk(0,0,1,0, 8'h00, 1, 8'h22, 1, 5);
    vt[12] = mk(0,0,1,0, 8'h00, 1, 8'h22, 1, 5);
    vt[13] = mk(0,0,0,1, 8'h33, 0, zz,    1, 5);
    vt[14] = mk(0,0,1,1, 8'h44, 1, 8'h33, 1, 5);
    vt[15] = mk(0,0,1,0, 8'h00, 1, 8'h44, 1, 5);
    vt[16] = mk(0,1,0,0, 8'h02, 0, zz,    1, 2);
    vt[17] = mk(0,1,0,1, 8'h07, 0, zz,    1, 7);
    vt[18] = mk(0,0,1,0, 8'h00, 1, 8'h00, 1, 7);
    vt[19] = mk(0,1,0,0, 8'h02, 0, zz,    1, 2);
    vt[20] = mk(0,0,1,0, 8'h00, 1, 8'h07, 1, 2);
    vt[21] = mk(1,0,0,0, 8'hFE, 0, zz,    0, 2);
    vt[22] = mk(0,1,0,0, 8'hFD, 0, zz,    0, 5);
    vt[23] = mk(0,0,1,0, 8'h00, 1, 8'h11, 0, 5);
    vt[24] = mk(0,0,0,0, 8'h00, 0, zz,    0, 5);

    idle();
    rst = 1'b1;
    #3;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_bus",   {24'b0, out_bus},   {24'b0, zz});
    check("rst_bank",  {31'b0, out_bank},  32'd0);
    check("rst_addr",  {29'b0, out_addr},  32'd0);
    check("rst_busy",  {31'b0, out_busy},  32'd1);

    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) tick();
    check("mid_sweep_busy", {31'b0, out_busy}, 32'd1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    run_sweep(1'b1, cyc, quiet);
    check("sweep_len", cyc, NLOC);
    check("sweep_strobes_ignored", {31'b0, quiet}, 32'd1);

    for (int b = 0; b < (1 << BB); b++)
      for (int a = 0; a < (1 << AW); a++)
        read_loc(b[BB-1:0], a[AW-1:0], 8'h00);

    // Return to bank 0 / addr 0 so the table starts from a known register state.
    in_mbs_wr_enable = 1'b1; in_addr_wr_enable = 1'b1; in_bus = 8'h00;
    tick();
    idle();

    for (int i = 0; i < NV; i++) begin
      in_mbs_wr_enable  = vt[i].mbs;
      in_addr_wr_enable = vt[i].aw;
      in_read_enable    = vt[i].rd;
      in_wr_enable      = vt[i].wr;
      in_bus            = vt[i].bus;
      tick();
      idle();
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ev});
      check($sformatf("v%0d_bus", i),   {24'b0, out_bus},   {24'b0, vt[i].eb});
      check($sformatf("v%0d_bank", i),  {31'b0, out_bank},  {31'b0, vt[i].ebank});
      check($sformatf("v%0d_addr", i),  {29'b0, out_addr},  {29'b0, vt[i].eaddr});
    end

    // Reset arriving while read data is on the bus must drop it at once.
    in_read_enable = 1'b1;
    tick();
    idle();
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_bus",   {24'b0, out_bus},   {24'b0, zz});
    check("async_rst_busy",  {31'b0, out_busy},  32'd1);
    check("async_rst_bank",  {31'b0, out_bank},  32'd0);
    rst = 1'b0;
    run_sweep(1'b0, cyc, quiet);
    check("resweep_len", cyc, NLOC);
    read_loc(1'b1, 3'd5, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
